fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and instruction-fetch stage of the LEGv8 microprocessor. It sits directly upstream of the 64-entry instruction memory, which has a one-cycle synchronous read. The block drives the memory address, realigns the registered memory output with the address that produced it, and presents a valid-qualified instruction/PC pair to decode. It also supports stall, branch redirect, halt, and a fetch counter.

## Interface
- RESET_PC, 32'd0: PC value loaded on reset (word address).
- CNT_W, 16: width of the fetched-instruction counter.

- clk  in  1  rising-edge clock, shared with the instruction memory.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decode cannot accept; hold the current output.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target word address; sampled when redirect_valid=1.
- halt  in  1  stop fetching; takes effect at the next edge.
- imem_addr  out  32  address to the instruction memory (combinational).
- imem_data  in  32  instruction memory output (registered inside the memory).
- if_instr  out  32  fetched instruction; equals imem_data.
- if_pc  out  32  address of if_instr.
- if_valid  out  1  if_instr/if_pc are a real fetch.
- fetch_count  out  CNT_W  saturating count of consumed instructions.

## Operation
- Addressing is by word: the PC increments by 1 per fetch, modulo 2^32 (0xFFFFFFFF wraps to 0). The memory decodes only the low address bits, so aliasing is its own concern.
- Registers:
  - pc: next address to fetch.
  - pend_pc / pend_v: the address issued on the last edge, and whether it is valid.
  - state: RUN or HALTED.
  - fetch_count.
- Outputs:
  - if_pc = pend_pc.
  - if_valid = pend_v & (state==RUN) & ~redirect_valid. A redirect kills the wrong-path instruction combinationally.
- imem_addr mux, in priority order:
  - redirect_valid: redirect_pc.
  - state==RUN and stall: pend_pc. This replays the same word, so the memory output stays unchanged next cycle.
  - Otherwise: pc.
- Edge actions, in priority order (reset is asynchronous and highest):
  - reset: pc=RESET_PC, pend_pc=0, pend_v=0, state=RUN, fetch_count=0.
  - redirect_valid: pend_pc=redirect_pc, pend_v=1, pc=redirect_pc+1, state=RUN. Stall and halt are ignored this cycle.
  - halt (state RUN): state=HALTED, pend_v=0, pc held. The instruction shown this cycle is consumed only if stall=0.
  - state HALTED: all registers hold. Only a redirect or reset leaves HALTED.
  - stall: pc, pend_pc and pend_v hold.
  - advance: pend_pc=pc, pend_v=1, pc=pc+1.
- Consume: an instruction is consumed at an edge when if_valid=1 and stall=0.
- fetch_count increments by 1 on each consume and saturates at all-ones.

## Timing
- Reset values: imem_addr=RESET_PC (in the absence of a redirect), if_valid=0, if_pc=0, fetch_count=0. if_instr follows imem_data, whose value during reset is not constrained.
- First cycle after rst_n rises: if_valid=0.
- Second cycle after rst_n rises: if_valid=1, if_pc=RESET_PC.
- Throughput: one instruction per cycle with no stall.
- Fetch latency: one cycle from imem_addr to if_instr.
- Redirect: zero bubbles. The cycle after a redirect shows if_pc=redirect_pc with if_valid=1.
- Stall: any number of cycles. if_instr, if_pc and if_valid are stable throughout, and the same instruction is consumed exactly once when stall drops.
- Simultaneous events:
  - redirect and stall: redirect wins, and the displayed instruction is killed.
  - redirect and halt: redirect wins, and the state stays RUN.
  - halt and stall: the block halts, and the displayed instruction is not consumed.
- Reset mid-operation: immediate clear regardless of state. Any in-flight memory read is discarded because pend_v=0.

## Test plan
- Reset and sequential fetch: load memory words 0..5 with distinct values, release rst_n, hold stall/redirect/halt low. Required: if_valid=0 for 1 cycle, then if_pc=0,1,2,3,4,5 on consecutive cycles with matching if_instr, and fetch_count=6 after 6 consumes.
- Stall: raise stall for 3 cycles while if_pc=2. Required: if_pc=2 and if_instr=mem[2] for 4 cycles, if_pc=3 on the next cycle, and fetch_count incremented once for word 2.
- Redirect: assert redirect_valid with redirect_pc=9 while if_pc=4, then repeat with stall=1 in the same cycle. Required: if_valid=0 in the redirect cycle, then if_pc=9, 10, 11. Word 4 is not counted.
- Halt: assert halt for 1 cycle at if_pc=6 with stall=0. Required: word 6 is consumed, then if_valid=0 indefinitely and imem_addr=7 held. A later redirect to 1 gives if_pc=1 on the next cycle.
- Reset mid-stream: drop rst_n asynchronously mid-cycle at if_pc=8 while stalled. Required: if_valid=0 and fetch_count=0 immediately, then restart from RESET_PC.
- Wrap and saturation: redirect to 0xFFFFFFFF, then run with CNT_W=4. Required: if_pc=0xFFFFFFFF, then 0, then 1, and fetch_count stops at 15.

Source files
------------

// File: rtl/fetch_unit.sv
// LEGv8 program-counter / instruction-fetch stage in front of a 1-cycle synchronous imem.
// Realigns the registered memory output with its address and handles stall, redirect and halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             if_valid,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend_v;
  logic        consume;

  assign if_instr = imem_data;
  assign if_pc    = pend_pc;
  assign if_valid = pend_v & (state == RUN) & ~redirect_valid;
  assign consume  = if_valid & ~stall;

  // Replaying pend_pc during a stall keeps the memory output frozen on the shown word.
  always_comb begin
    imem_addr = pc;
    if (redirect_valid)
      imem_addr = redirect_pc;
    else if ((state == RUN) && stall)
      imem_addr = pend_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pend_pc     <= 32'd0;
      pend_v      <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (redirect_valid) begin
        pend_pc <= redirect_pc;
        pend_v  <= 1'b1;
        pc      <= redirect_pc + 32'd1;
        state   <= RUN;
      end else if ((state == RUN) && halt) begin
        state  <= HALTED;
        pend_v <= 1'b0;
      end else if ((state == RUN) && !stall) begin
        pend_pc <= pc;
        pend_v  <= 1'b1;
        pc      <= pc + 32'd1;
      end

      if (consume && (fetch_count != {CNT_W{1'b1}}))
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected PCs, a negedge monitor
// checks every consumed instruction against the queue.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [3:0]  fetch_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[64];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'd0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {8'hA5, 8'h3C, 10'd0, a[5:0]};
  endfunction

  initial for (int i = 0; i < 64; i++) mem[i] = word(32'(i));

  always @(posedge clk) imem_data <= mem[imem_addr[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
  endtask

  // Monitor: every instruction consumed at the next edge must match the queue head.
  always @(negedge clk) begin
    if (if_valid === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_consume_pc", if_pc, 32'hDEAD_DEAD);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("consume_pc", if_pc, e);
        chk("consume_instr", if_instr, word(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
    tick(); tick();
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_fetch_count", {28'd0, fetch_count}, 32'd0);

    // Sequential fetch 0..5, then halt on word 6 (consumed).
    push_range(32'd0, 7);
    rst_n = 1'b1;
    #1 chk("first_cycle_invalid", {31'd0, if_valid}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("seq_pc", if_pc, 32'(k));
      chk("seq_valid", {31'd0, if_valid}, 32'd1);
    end
    tick();
    chk("count_after_6", {28'd0, fetch_count}, 32'd6);
    chk("halt_at_pc", if_pc, 32'd6);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    #1;
    chk("halt_count", {28'd0, fetch_count}, 32'd7);
    for (int k = 0; k < 4; k++) begin
      chk("halted_invalid", {31'd0, if_valid}, 32'd0);
      chk("halted_addr", imem_addr, 32'd7);
      tick();
    end

    // Redirect out of HALTED to 1, then stall on word 2.
    push_range(32'd1, 3);
    redirect_valid = 1'b1; redirect_pc = 32'd1;
    #1 chk("redir1_addr", imem_addr, 32'd1);
    tick();
    redirect_valid = 1'b0;
    #1 chk("redir1_pc", if_pc, 32'd1);
    chk("redir1_valid", {31'd0, if_valid}, 32'd1);
    tick();
    stall = 1'b1;
    #1 chk("stall_addr", imem_addr, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) stall = 1'b0;
      #1;
      chk("stall_pc", if_pc, 32'd2);
      chk("stall_instr", if_instr, word(32'd2));
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
    end
    tick();
    chk("after_stall_pc", if_pc, 32'd3);
    chk("after_stall_count", {28'd0, fetch_count}, 32'd9);

    // Redirect to 9 while showing 4 (killed).
    tick();
    chk("pre_redir_pc", if_pc, 32'd4);
    push_range(32'd9, 3);
    redirect_valid = 1'b1; redirect_pc = 32'd9;
    #1 chk("redir_kill", {31'd0, if_valid}, 32'd0);
    chk("redir_count_before", {28'd0, fetch_count}, 32'd10);
    tick();
    redirect_valid = 1'b0;
    #1 chk("redir9_pc", if_pc, 32'd9);
    chk("redir9_count", {28'd0, fetch_count}, 32'd10);
    tick(); tick(); tick();
    chk("pre_redir2_pc", if_pc, 32'd12);

    // Redirect with simultaneous stall: redirect wins.
    push_range(32'd9, 3);
    redirect_valid = 1'b1; redirect_pc = 32'd9; stall = 1'b1;
    #1 chk("redir_stall_kill", {31'd0, if_valid}, 32'd0);
    chk("redir_stall_addr", imem_addr, 32'd9);
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    #1 chk("redir_stall_pc", if_pc, 32'd9);
    chk("redir_stall_count", {28'd0, fetch_count}, 32'd13);
    tick(); tick(); tick();

    // Redirect to 8, stall there, then asynchronous reset mid-cycle.
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    tick();
    redirect_valid = 1'b0; stall = 1'b1;
    #1 chk("sat_count_15", {28'd0, fetch_count}, 32'd15);
    tick();
    chk("stalled_pc8", if_pc, 32'd8);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("async_rst_count", {28'd0, fetch_count}, 32'd0);
    chk("async_rst_pc", if_pc, 32'd0);
    stall = 1'b0;

    // Restart from RESET_PC, then redirect to 0xFFFFFFFF and wrap.
    push_range(32'd0, 3);
    tick();
    rst_n = 1'b1;
    #1 chk("restart_invalid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("restart_pc0", if_pc, 32'd0);
    tick(); tick(); tick();
    chk("pre_wrap_pc", if_pc, 32'd3);
    push_range(32'hFFFF_FFFF, 15);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1 chk("wrap_pc_max", if_pc, 32'hFFFF_FFFF);
    chk("wrap_count", {28'd0, fetch_count}, 32'd3);
    tick();
    chk("wrap_pc_0", if_pc, 32'd0);
    tick();
    chk("wrap_pc_1", if_pc, 32'd1);
    for (int k = 2; k < 14; k++) tick();
    tick();
    chk("final_pc14", if_pc, 32'd14);
    halt = 1'b1; stall = 1'b1;
    #1 chk("final_sat_count", {28'd0, fetch_count}, 32'd15);
    tick();
    halt = 1'b0; stall = 1'b0;
    #1;
    chk("halt_stall_invalid", {31'd0, if_valid}, 32'd0);
    chk("halt_stall_count", {28'd0, fetch_count}, 32'd15);
    chk("halt_stall_addr", imem_addr, 32'd15);
    tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
